mult8_seq_ctrl: RTL

- Sequencer that computes an unsigned 8x8 -> 16-bit product by time-multiplexing one shared 4x4 array multiplier (8-bit product) over four partial-product steps.
- Sits between a valid/ready operand source and a valid/ready result sink.
- Drives the multiplier's x/y inputs and accumulates its o output with shifts.
- The multiplier instance lives outside this block.

---
 rtl/mult8_seq_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/mult8_seq_ctrl.sv
// mult8_seq_ctrl: unsigned 8x8 -> 16-bit multiply sequencer.
// One external 4x4 multiplier is time-shared over four nibble-pair
// partial products, and the partial products are summed into a
// 16-bit accumulator with the appropriate shifts.
// MUL_LAT selects between a combinational multiplier (0) and a
// multiplier with a registered output (1).
// Any other MUL_LAT value is handled like 1.

module mult8_seq_ctrl #(
   parameter int MUL_LAT = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_a,
   input  logic [7:0]  in_b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_p,
   output logic        busy,
   output logic [3:0]  mul_x,
   output logic [3:0]  mul_y,
   input  logic [7:0]  mul_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      CAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   // A registered multiplier needs an extra capture cycle per step
   localparam logic REG_MUL = (MUL_LAT != 0);

   state_t      state;
   state_t      state_next;
   logic [1:0]  step;
   logic [1:0]  step_inc;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [15:0] acc;
   logic [15:0] partial;
   logic [15:0] acc_sum;
   logic        accept;
   logic        sample;
   logic        last_step;

   assign accept    = in_valid & in_ready;
   assign sample    = ((state == MUL) & ~REG_MUL) | (state == CAP);
   assign last_step = (step == 2'd3);
   assign step_inc  = step + 2'd1;
   assign acc_sum   = acc + partial;

   // Place the multiplier product at the weight of the nibble pair in use
   always_comb begin
      partial = {8'h00, mul_o};
      case (step)
         2'd0:       partial = {8'h00, mul_o};
         2'd1, 2'd2: partial = {4'h0, mul_o, 4'h0};
         default:    partial = {mul_o, 8'h00};
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decision
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) state_next = MUL;
         end
         MUL: begin
            if (REG_MUL)        state_next = CAP;
            else if (last_step) state_next = DONE;
         end
         CAP: begin
            state_next = last_step ? DONE : MUL;
         end
         DONE: begin
            if (accept)         state_next = MUL;
            else if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from the current state
   always_comb begin
      in_ready  = ~rst & ((state == IDLE) | ((state == DONE) & out_ready));
      out_valid = (state == DONE);
      busy      = (state == MUL) | (state == CAP);
   end

   // Operand capture, step sequencing, accumulation and multiplier drive
   always_ff @(posedge clk) begin
      if (rst) begin
         a     <= 8'h00;
         b     <= 8'h00;
         acc   <= 16'h0000;
         step  <= 2'd0;
         out_p <= 16'h0000;
         mul_x <= 4'h0;
         mul_y <= 4'h0;
      end else if (accept) begin
         a     <= in_a;
         b     <= in_b;
         acc   <= 16'h0000;
         step  <= 2'd0;
         mul_x <= in_a[3:0];
         mul_y <= in_b[3:0];
      end else if (sample) begin
         acc <= acc_sum;
         if (last_step) begin
            out_p <= acc_sum;
            step  <= 2'd0;
            mul_x <= 4'h0;
            mul_y <= 4'h0;
         end else begin
            step  <= step_inc;
            mul_x <= step_inc[0] ? a[7:4] : a[3:0];
            mul_y <= step_inc[1] ? b[7:4] : b[3:0];
         end
      end
   end

   // Only combinational and single-register multipliers are supported
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (MUL_LAT == 0 || MUL_LAT == 1);
      end
   end

endmodule
